// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq CPU and its boot loader.
// Holds the default memory geometry used by the datapath, the memory and the
// loader, plus the loader state encoding.
package subleq_pkg;

  localparam int WORD_W_DEF = 64;  // memory word width in bits
  localparam int ADDR_W_DEF = 10;  // memory address width in bits
  localparam int HDR_BYTES  = 8;   // the word-count header is always 64 bits

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/subleq_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word packer with a byte counter.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   clear         synchronous clear of counter and word
//   push          accept byte_data into the slot selected by the counter
//   last_idx      index of the final byte of the current word
//   byte_data     incoming byte
//   word          packed word; byte k sits at bits [8k+7:8k]
//   word_full     high when this push completes the word
module byte_packer #(
  parameter int NBYTES = 8,
  parameter int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [CNT_W-1:0]      last_idx,
  input  logic [7:0]            byte_data,
  output logic [8*NBYTES-1:0]   word,
  output logic                  word_full
);

  logic [CNT_W-1:0]    count_r;
  logic [8*NBYTES-1:0] word_r;

  // The completing push is flagged combinationally so the owner can change
  // state on the same edge that stores the final byte.
  assign word_full = push && (count_r == last_idx);
  assign word      = word_r;

  // Byte slot write and counter; the counter wraps to 0 when a word completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
      word_r  <= '0;
    end else if (clear) begin
      count_r <= '0;
      word_r  <= '0;
    end else if (push) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (count_r == CNT_W'(k)) begin
          word_r[8*k +: 8] <= byte_data;
        end
      end
      count_r <= word_full ? '0 : count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/subleq_loader.sv
// subleq_loader: boot stage that streams a program image into memory.
// Image format: 8-byte little-endian word count N, then N words of
// BYTES_PER_WORD little-endian bytes each. Words are written to addresses
// 0..N-1, after which the CPU is released from reset.
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   load_start            pulse that starts a load from IDLE, RUN or ERR
//   in_valid/in_ready     byte-stream handshake, in_data the byte
//   mem_we/addr/wdata     one-cycle memory write per packed word
//   cpu_rst               active-high CPU reset, low only in RUN
//   done                  image loaded, CPU running
//   err                   header word count larger than memory depth
module subleq_loader
  import subleq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam int PACK_BYTES     = (BYTES_PER_WORD > HDR_BYTES) ? BYTES_PER_WORD : HDR_BYTES;
  localparam int CNT_W          = $clog2(PACK_BYTES);
  localparam int DEPTH          = 2 ** ADDR_W;

  loader_state_e         state_r, next_state_s;
  logic                  in_ready_r, mem_we_r, cpu_rst_r, done_r, err_r;
  logic [ADDR_W-1:0]     addr_r, n_last_r;
  logic                  fire_s, word_full_s, clear_s;
  logic [CNT_W-1:0]      last_idx_s;
  logic [8*PACK_BYTES-1:0] pack_word_s;
  logic [63:0]           hdr_n_s;

  assign fire_s     = in_valid && in_ready_r;
  assign last_idx_s = (state_r == ST_HDR) ? CNT_W'(HDR_BYTES - 1) : CNT_W'(BYTES_PER_WORD - 1);
  // Header value including the byte being accepted this cycle.
  assign hdr_n_s    = {in_data, pack_word_s[55:0]};

  byte_packer #(.NBYTES(PACK_BYTES), .CNT_W(CNT_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .push      (fire_s),
    .last_idx  (last_idx_s),
    .byte_data (in_data),
    .word      (pack_word_s),
    .word_full (word_full_s)
  );

  // Next-state logic and packer clear.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) next_state_s = ST_HDR;
        else            next_state_s = ST_IDLE;
      end
      ST_HDR: begin
        if (word_full_s) begin
          if (hdr_n_s == 64'd0)            next_state_s = ST_RUN;
          else if (hdr_n_s > 64'(DEPTH))   next_state_s = ST_ERR;
          else                             next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (word_full_s) next_state_s = ST_WRITE;
        else             next_state_s = ST_DATA;
      end
      ST_WRITE: begin
        if (addr_r == n_last_r) next_state_s = ST_RUN;
        else                    next_state_s = ST_DATA;
      end
      ST_RUN: begin
        if (load_start) next_state_s = ST_HDR;
        else            next_state_s = ST_RUN;
      end
      ST_ERR: begin
        if (load_start) next_state_s = ST_HDR;
        else            next_state_s = ST_ERR;
      end
      default: next_state_s = ST_IDLE;
    endcase
    if ((next_state_s == ST_HDR) && (state_r != ST_HDR)) begin
      clear_s = 1'b1;
    end else if ((state_r == ST_WRITE) && (next_state_s == ST_DATA)) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == ST_HDR) || (next_state_s == ST_DATA);
      mem_we_r   <= (next_state_s == ST_WRITE);
      cpu_rst_r  <= (next_state_s != ST_RUN);
      done_r     <= (next_state_s == ST_RUN);
      err_r      <= (next_state_s == ST_ERR);
    end
  end

  // Word index and last index. The index only advances toward another DATA
  // word, so after the final write of a full-depth image it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r   <= '0;
      n_last_r <= '0;
    end else begin
      if ((next_state_s == ST_HDR) && (state_r != ST_HDR)) begin
        addr_r <= '0;
      end else if ((state_r == ST_WRITE) && (next_state_s == ST_DATA)) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
      // N is known to be 1..DEPTH whenever DATA follows, so N-1 fits ADDR_W.
      if ((state_r == ST_HDR) && word_full_s) begin
        n_last_r <= ADDR_W'(hdr_n_s - 64'd1);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = pack_word_s[WORD_W-1:0];
  assign cpu_rst   = cpu_rst_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_subleq_loader.sv
// Testbench for subleq_loader: expected memory writes are queued as image
// bytes are driven and compared by a monitor whenever mem_we is seen.
module tb_subleq_loader;

  localparam int WORD_W = 64;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [63:0] last_wr_addr = 64'd0;

  subleq_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      check_val("in_ready_in_write", 64'(in_ready), 64'd0);
      check_val("cpu_rst_in_write", 64'(cpu_rst), 64'd1);
      if (exp_addr_q.size() == 0) begin
        check_val("write_expected", 64'(exp_addr_q.size()), 64'd1);
      end else begin
        check_val("wr_addr", 64'(mem_addr), exp_addr_q.pop_front());
        check_val("wr_data", mem_wdata, exp_data_q.pop_front());
        last_wr_addr = 64'(mem_addr);
      end
    end
  end

  function automatic logic [63:0] word_of(input int i);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(i * 16 + k + 1);
    w[63:56] = w[63:56] ^ 8'(i >> 4);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) check_val("byte_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [63:0] w, input bit gap);
    for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], gap);
  endtask

  // Header plus n words; returns in the WRITE cycle of the last word.
  task automatic load_image(input int n, input bit gap, input bit mid_start);
    logic [63:0] w;
    send_word(64'(n), gap);
    for (int i = 0; i < n; i++) begin
      w = word_of(i);
      exp_addr_q.push_back(64'(i));
      exp_data_q.push_back(w);
      for (int k = 0; k < 8; k++) begin
        send_byte(w[8*k +: 8], gap);
        if (mid_start && i == 0 && k == 3) pulse_start();
      end
    end
  endtask

  initial begin
    // Reset state while rst is held low
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_mem_we", 64'(mem_we), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_val("rst_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b1;
    step();
    check_val("idle_in_ready", 64'(in_ready), 64'd0);

    // Basic load, valid held high, with an ignored load_start mid-word
    pulse_start();
    check_val("hdr_in_ready", 64'(in_ready), 64'd1);
    load_image(2, 1'b0, 1'b1);
    check_val("basic_last_we", 64'(mem_we), 64'd1);
    check_val("basic_last_cpu_rst", 64'(cpu_rst), 64'd1);
    check_val("basic_last_done", 64'(done), 64'd0);
    step();
    check_val("basic_cpu_rst", 64'(cpu_rst), 64'd0);
    check_val("basic_done", 64'(done), 64'd1);
    check_val("basic_q_empty", 64'(exp_addr_q.size()), 64'd0);

    // Reload from RUN, then the same image with gaps
    pulse_start();
    check_val("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    check_val("reload_done", 64'(done), 64'd0);
    check_val("reload_in_ready", 64'(in_ready), 64'd1);
    load_image(2, 1'b1, 1'b0);
    step();
    check_val("gap_done", 64'(done), 64'd1);
    check_val("gap_q_empty", 64'(exp_addr_q.size()), 64'd0);

    // Zero-length image
    pulse_start();
    send_word(64'd0, 1'b0);
    check_val("zero_done", 64'(done), 64'd1);
    check_val("zero_cpu_rst", 64'(cpu_rst), 64'd0);
    check_val("zero_in_ready", 64'(in_ready), 64'd0);

    // Overflow header
    pulse_start();
    send_word(64'(DEPTH + 1), 1'b0);
    check_val("ovf_err", 64'(err), 64'd1);
    check_val("ovf_cpu_rst", 64'(cpu_rst), 64'd1);
    check_val("ovf_in_ready", 64'(in_ready), 64'd0);
    check_val("ovf_done", 64'(done), 64'd0);
    repeat (3) step();
    check_val("ovf_err_hold", 64'(err), 64'd1);
    pulse_start();
    check_val("ovf_err_clear", 64'(err), 64'd0);
    check_val("ovf_hdr_ready", 64'(in_ready), 64'd1);

    // Reset mid-DATA
    send_word(64'd1, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'(8'hA0 + k), 1'b0);
    rst = 1'b0;
    #1;
    check_val("abort_in_ready_async", 64'(in_ready), 64'd0);
    repeat (3) step();
    check_val("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    check_val("abort_mem_we", 64'(mem_we), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_err", 64'(err), 64'd0);
    rst = 1'b1;
    step();
    check_val("abort_idle_ready", 64'(in_ready), 64'd0);
    check_val("abort_idle_cpu_rst", 64'(cpu_rst), 64'd1);

    // Full-depth image
    pulse_start();
    load_image(DEPTH, 1'b0, 1'b0);
    check_val("full_last_we", 64'(mem_we), 64'd1);
    step();
    check_val("full_last_addr", last_wr_addr, 64'(DEPTH - 1));
    check_val("full_done", 64'(done), 64'd1);
    check_val("full_q_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/subleq_loader.md
Name: subleq_loader

Overview:
- Upstream boot stage for the subleq CPU.
- Receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 64-bit words.
- Writes each packed word into instruction/data memory at consecutive addresses from 0.
- Holds the CPU in reset until the image is complete, then releases it.

Parameters:
- WORD_W, 64, memory word width; must be a multiple of 8.
- ADDR_W, 10, memory address width; memory depth DEPTH = 2**ADDR_W words.
- BYTES_PER_WORD, WORD_W/8, derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; one clock domain.
- load_start  input  1  single-cycle pulse that begins a load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  WORD_W  write data.
- cpu_rst  output  1  active-high reset to the CPU top.
- done  output  1  image loaded and CPU running.
- err  output  1  header word count exceeds DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, cpu_rst=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, byte count=0, word count=0.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready.
  - in_ready is a registered output.
  - in_ready=1 only in HDR and DATA.
  - in_data is ignored when no transfer occurs.
- Byte packing is little-endian: byte k of a word goes to bits [8k+7:8k].
- States:
  - IDLE: load_start -> HDR.
  - HDR: accept 8 bytes forming word count N (64-bit, little-endian).
    - After the 8th byte: N==0 -> RUN; N>DEPTH -> ERR; otherwise -> DATA.
  - DATA: accept BYTES_PER_WORD bytes. After the last byte -> WRITE on the next edge.
  - WRITE: mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = packed word. in_ready=0.
    - Next state: word index == N-1 -> RUN; otherwise -> DATA.
    - Word index increments on leaving WRITE.
  - RUN: cpu_rst=0, done=1, in_ready=0. load_start -> HDR, with cpu_rst=1 and done=0 from the next cycle.
  - ERR: err=1, cpu_rst=1, in_ready=0. load_start -> HDR, clears err.
- cpu_rst=1 in every state except RUN. The CPU never executes a partially written image.
- Throughput: one word per BYTES_PER_WORD+1 cycles with in_valid held high.
- Word count N==DEPTH is legal: the last write goes to address DEPTH-1 and mem_addr must not wrap before the RUN transition.
- load_start in HDR, DATA or WRITE is ignored. A load is not restartable mid-image; rst is the only abort.
- rst asserted mid-load aborts immediately to IDLE. Bytes already written to memory remain but are irrelevant, since cpu_rst=1.
- The byte counter clears on entering HDR and on entering DATA from WRITE.

Decomposition:
- Shared package subleq_pkg holds:
  - WORD_W and ADDR_W defaults, also used by the subleq datapath/memory;
  - the loader state encoding (IDLE, HDR, DATA, WRITE, RUN, ERR as 3-bit localparams).
- Sub-module byte_packer: shift register plus byte counter.
  - Inputs: clk, rst, clear, push, byte.
  - Outputs: word, word_full.
  - Shared by HDR and DATA.
- The FSM, address counter and outputs stay in subleq_loader.

Test Plan:
- Reset: rst=0 mid-DATA for 3 cycles -> state IDLE, cpu_rst=1, in_ready=0, mem_we=0, done=0, err=0.
- Basic load:
  - Stimulus: load_start, then header N=2 (bytes 02 00 00 00 00 00 00 00), then bytes 01..08 and 11..18.
  - Expected: mem_we pulses twice, at addr 0 with data 0x0807060504030201 and at addr 1 with 0x1817161514131211.
  - Expected: cpu_rst falls and done rises the cycle after the second write.
- Backpressure/gaps: same image with in_valid toggled every other cycle -> identical writes; no byte lost or duplicated; in_ready=0 during each WRITE cycle.
- Zero length: header N=0 -> no mem_we; RUN immediately after the 8th header byte.
- Overflow: header N=DEPTH+1 (1025 with ADDR_W=10) -> err=1, cpu_rst stays 1, no mem_we. A subsequent load_start clears err and enters HDR.
- Reload and boundary:
  - From RUN, load_start -> cpu_rst=1 the next cycle.
  - Load with N=DEPTH -> last write at addr 1023, then done=1.
